// File: rtl/mem_if_pkg.sv
`default_nettype none
// mem_if_pkg: encodings and FSM state type shared by the LSU memory master and its lane aligner.
package mem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Reserved size 3 is treated as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_master_lane_align.sv
`default_nettype none
// lsu_lane_align: combinational byte-lane steering -- store strobe/replication and load shift/extension.
module lsu_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  st_addr_lo,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata_rep,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    function automatic logic [35:0] store_lanes(input logic [1:0] size, input logic [1:0] addr_lo,
                                                input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4'b0001 << addr_lo, {4{wdata[7:0]}}};
            SZ_HALF: return {4'b0011 << {addr_lo[1], 1'b0}, {2{wdata[15:0]}}};
            default: return {4'hF, wdata};
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] addr_lo,
                                                 input logic is_unsigned, input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        b = raw[{addr_lo, 3'b000} +: 8];
        h = raw[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return {{24{~is_unsigned & b[7]}}, b};
            SZ_HALF: return {{16{~is_unsigned & h[15]}}, h};
            default: return raw;
        endcase
    endfunction

    assign {st_strb, st_wdata_rep} = store_lanes(st_size, st_addr_lo, st_wdata);
    assign ld_data = load_extract(ld_size, ld_addr_lo, ld_unsigned, ld_raw);

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// lsu_mem_master: single-outstanding load/store initiator on a split cmd/r/w memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests skip the bus and return resp_err.
module lsu_mem_master
    import mem_if_pkg::*;
#(
    parameter int p_ADDR_BITS = 32,
    parameter int p_DATA_BITS = 32,
    parameter int p_STRB_BITS = p_DATA_BITS / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [p_ADDR_BITS-1:0] req_addr,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [p_DATA_BITS-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [p_DATA_BITS-1:0] resp_rdata,
    output logic                   resp_err,
    output logic [p_ADDR_BITS-1:0] mem_addr,
    output logic                   mem_cmd,
    output logic [1:0]             mem_size,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    input  logic                   mem_r_valid,
    output logic                   mem_r_ready,
    input  logic [p_DATA_BITS-1:0] mem_r_data,
    input  logic                   mem_r_resp,
    output logic                   mem_w_valid,
    input  logic                   mem_w_ready,
    output logic [p_STRB_BITS-1:0] mem_w_strb,
    output logic [p_DATA_BITS-1:0] mem_w_data,
    input  logic                   mem_w_resp
);

    lsu_state_t state, next_state;

    logic        unsigned_q;
    logic [3:0]  st_strb;
    logic [31:0] st_wdata_rep;
    logic [31:0] ld_data;
    logic        accept, cmd_fire, w_fire, cmd_done, w_done, misaligned;

    lsu_lane_align u_align (
        .st_addr_lo   (req_addr[1:0]),
        .st_size      (req_size),
        .st_wdata     (req_wdata),
        .st_strb      (st_strb),
        .st_wdata_rep (st_wdata_rep),
        .ld_addr_lo   (mem_addr[1:0]),
        .ld_size      (mem_size),
        .ld_unsigned  (unsigned_q),
        .ld_raw       (mem_r_data),
        .ld_data      (ld_data)
    );

    // Held low while reset is asserted even though the state already reads IDLE.
    assign req_ready = (state == ST_IDLE) && rst;
    assign accept    = req_valid && req_ready;
    assign cmd_fire  = mem_valid && mem_ready;
    assign w_fire    = mem_w_valid && mem_w_ready;
    assign cmd_done  = !mem_valid || mem_ready;
    assign w_done    = !mem_w_valid || mem_w_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept)                next_state = misaligned ? ST_RESP : ST_CMD;
            ST_CMD:   if (cmd_done && w_done)    next_state = (mem_cmd == CMD_WR) ? ST_RESP : ST_RDATA;
            ST_RDATA: if (mem_r_valid)           next_state = ST_RESP;
            ST_RESP:  if (resp_ready)            next_state = ST_IDLE;
            default:                             next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid   <= 1'b0;
            mem_w_valid <= 1'b0;
            mem_r_ready <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= '0;
            mem_addr    <= '0;
            mem_cmd     <= CMD_RD;
            mem_size    <= SZ_BYTE;
            mem_w_strb  <= '0;
            mem_w_data  <= '0;
            unsigned_q  <= 1'b0;
        end else begin
            mem_r_ready <= (next_state == ST_RDATA);
            resp_valid  <= (next_state == ST_RESP);
            if (cmd_fire) begin
                mem_valid <= 1'b0;
            end
            // Write error is only meaningful in the cycle its data beat is accepted.
            if (w_fire) begin
                mem_w_valid <= 1'b0;
                resp_err    <= mem_w_resp;
            end
            if (accept) begin
                mem_addr    <= req_addr;
                mem_cmd     <= req_write;
                mem_size    <= req_size;
                unsigned_q  <= req_unsigned;
                mem_w_strb  <= req_write ? st_strb : '0;
                mem_w_data  <= st_wdata_rep;
                resp_rdata  <= '0;
                resp_err    <= misaligned;
                mem_valid   <= !misaligned;
                mem_w_valid <= req_write && !misaligned;
            end
            if (state == ST_RDATA && mem_r_valid) begin
                resp_rdata <= ld_data;
                resp_err   <= mem_r_resp;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// tb_lsu_mem_master: table-driven load/store vectors with a response scoreboard and a procedural responder.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        resp_valid, resp_ready = 1'b0, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_cmd, mem_valid, mem_ready = 1'b0;
    logic [1:0]  mem_size;
    logic        mem_r_valid = 1'b0, mem_r_ready, mem_r_resp = 1'b0;
    logic [31:0] mem_r_data = 32'hDEAD_BEEF;
    logic        mem_w_valid, mem_w_ready = 1'b0, mem_w_resp = 1'b0;
    logic [3:0]  mem_w_strb;
    logic [31:0] mem_w_data;

    lsu_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_cmd(mem_cmd), .mem_size(mem_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data),
        .mem_r_resp(mem_r_resp),
        .mem_w_valid(mem_w_valid), .mem_w_ready(mem_w_ready), .mem_w_strb(mem_w_strb),
        .mem_w_data(mem_w_data), .mem_w_resp(mem_w_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        rresp;
        logic        wresp;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        trap;
        int          cs, ws, rs;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pushes = 0;
    int          resp_cnt = 0;
    logic [32:0] sb[$];
    vec_t        vecs[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t ld(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                                input logic [31:0] rdata, input logic rresp,
                                input logic [31:0] exp, input logic err);
        vec_t v;
        v = '{1'b0, addr, size, uns, 32'h0, rdata, rresp, 1'b0, 4'h0, 32'h0, exp, err, 3, 1'b0, 0, 0, 0};
        return v;
    endfunction

    function automatic vec_t st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                                input logic wresp, input logic [3:0] strb, input logic [31:0] wdat);
        vec_t v;
        v = '{1'b1, addr, size, 1'b0, wdata, 32'h0, 1'b0, wresp, strb, wdat, 32'h0, wresp, 2, 1'b0, 0, 0, 0};
        return v;
    endfunction

    // Scoreboard consumer: every result handshake pops one expected {err, rdata}; stalled results must hold.
    logic        hold_prev = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_err;
    always @(negedge clk) begin
        if (rst) begin
            if (hold_prev) begin
                chk("resp_hold", {resp_valid, resp_err, resp_rdata}, {1'b1, prev_err, prev_rdata});
            end
            hold_prev  = resp_valid && !resp_ready;
            prev_rdata = resp_rdata;
            prev_err   = resp_err;
            if (resp_valid && resp_ready) begin
                logic [32:0] e;
                resp_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e[31:0]);
                    chk("resp_err", resp_err, e[32]);
                end
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {req_ready, mem_valid, mem_w_valid, mem_r_ready, resp_valid, resp_err,
                             mem_cmd, mem_size, mem_w_strb}, 64'd0);
        chk({tag, "_addr"}, mem_addr, 64'd0);
        chk({tag, "_wdata"}, mem_w_data, 64'd0);
        chk({tag, "_rdata"}, resp_rdata, 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   guard, a, c;
        logic cmd_seen, w_seen, proto_bad;
        string p;
        p = $sformatf("v%0d", idx);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_size = v.size;
        req_unsigned = v.uns; req_wdata = v.wdata;
        guard = 0;
        while (!req_ready && guard < 20) begin tick(); guard++; end
        if (guard >= 20) chk({p, "_req_ready_timeout"}, 64'd0, 64'd1);
        a = cyc;
        tick();
        req_valid = 1'b0; req_wdata = 32'h0BAD_0BAD;
        sb.push_back({v.exp_err, v.exp_rdata});
        pushes++;
        proto_bad = 1'b0;
        if (v.trap) begin
            chk({p, "_no_cmd"}, {mem_valid, mem_w_valid}, 64'd0);
        end else begin
            cmd_seen = 1'b0; w_seen = !v.write; c = 0;
            mem_w_resp = v.wresp;
            while (!(cmd_seen && w_seen) && c < 50) begin
                if (mem_valid !== !cmd_seen || mem_w_valid !== !w_seen) proto_bad = 1'b1;
                mem_ready   = (c >= v.cs);
                mem_w_ready = (c >= v.ws);
                if (mem_valid && mem_ready) begin
                    chk({p, "_mem_cmd"}, {mem_addr, mem_cmd, mem_size}, {v.addr, v.write, v.size});
                    cmd_seen = 1'b1;
                end
                if (mem_w_valid && mem_w_ready) begin
                    chk({p, "_mem_w"}, {mem_w_strb, mem_w_data}, {v.exp_strb, v.exp_wdata});
                    w_seen = 1'b1;
                end
                tick();
                c++;
            end
            mem_ready = 1'b0; mem_w_ready = 1'b0; mem_w_resp = 1'b0;
            if (c >= 50) chk({p, "_cmd_timeout"}, 64'd0, 64'd1);
            if (mem_valid || mem_w_valid) proto_bad = 1'b1;
            chk({p, "_protocol"}, proto_bad, 64'd0);
            if (!v.write) begin
                chk({p, "_r_ready"}, mem_r_ready, 64'd1);
                mem_r_valid = 1'b1; mem_r_data = v.rdata; mem_r_resp = v.rresp;
                tick();
                mem_r_valid = 1'b0; mem_r_data = 32'hDEAD_BEEF; mem_r_resp = 1'b0;
            end
        end
        guard = 0;
        while (!resp_valid && guard < 20) begin tick(); guard++; end
        if (guard >= 20) chk({p, "_resp_timeout"}, 64'd0, 64'd1);
        if (v.exp_lat >= 0) chk({p, "_latency"}, cyc - a, v.exp_lat);
        for (int k = 0; k < v.rs; k++) tick();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({p, "_after_resp"}, {resp_valid, req_ready}, {1'b0, 1'b1});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = ld(32'h103, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 1'b0);
        vecs[1]  = ld(32'h102, 2'd1, 1'b1, 32'h80FF_1234, 1'b0, 32'h0000_80FF, 1'b0);
        vecs[2]  = ld(32'h102, 2'd1, 1'b0, 32'h80FF_1234, 1'b0, 32'hFFFF_80FF, 1'b0);
        vecs[3]  = ld(32'h101, 2'd0, 1'b1, 32'h80FF_1234, 1'b0, 32'h0000_0012, 1'b0);
        vecs[4]  = ld(32'h102, 2'd0, 1'b0, 32'h80FF_1234, 1'b0, 32'hFFFF_FFFF, 1'b0);
        vecs[5]  = ld(32'h100, 2'd2, 1'b0, 32'h80FF_1234, 1'b0, 32'h80FF_1234, 1'b0);
        vecs[6]  = st(32'h201, 2'd0, 32'h0000_00AB, 1'b0, 4'b0010, 32'hABAB_ABAB);
        vecs[7]  = st(32'h202, 2'd1, 32'h1234_BEEF, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        vecs[8]  = st(32'h203, 2'd0, 32'hFFFF_FF5A, 1'b0, 4'b1000, 32'h5A5A_5A5A);
        vecs[9]  = st(32'h300, 2'd2, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'hCAFE_F00D);
        vecs[10] = ld(32'h104, 2'd3, 1'b0, 32'h1122_3344, 1'b0, 32'h1122_3344, 1'b0);
        vecs[10].cs = 1; vecs[10].rs = 1; vecs[10].exp_lat = -1;
        vecs[11] = ld(32'h100, 2'd0, 1'b0, 32'h0000_007F, 1'b1, 32'h0000_007F, 1'b1);
        vecs[12] = st(32'h500, 2'd2, 32'h1234_5678, 1'b0, 4'b1111, 32'h1234_5678);
        vecs[12].cs = 2; vecs[12].ws = 4; vecs[12].rs = 3; vecs[12].exp_lat = -1;
        vecs[13] = ld(32'h100, 2'd1, 1'b0, 32'h0000_8001, 1'b0, 32'hFFFF_8001, 1'b0);
        vecs[14] = st(32'h200, 2'd1, 32'h0000_00C3, 1'b0, 4'b0011, 32'h00C3_00C3);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[15] = ld(32'h102, 2'd2, 1'b0, 32'hA5A5_0F0F, 1'b0, 32'h0000_0000, 1'b1);
        vecs[15].trap = 1'b1; vecs[15].exp_lat = 1;
`else
        vecs[15] = ld(32'h102, 2'd2, 1'b0, 32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 1'b0);
`endif

        tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        chk("req_ready_post_reset", req_ready, 64'd1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Load aborted by reset while waiting for read data; a late r_valid must not surface.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400; req_size = 2'd2; req_unsigned = 1'b0;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("abort_in_rdata", {mem_r_ready, resp_valid}, {1'b1, 1'b0});
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        rst = 1'b1;
        mem_r_valid = 1'b1; mem_r_data = 32'h7777_7777; mem_r_resp = 1'b1;
        tick(); tick();
        chk("late_r_valid_ignored", {resp_valid, mem_r_ready, mem_valid, req_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
        mem_r_valid = 1'b0; mem_r_resp = 1'b0;
        tick();

        run_vec(vecs[0], 16);

        chk("sb_empty", sb.size(), 64'd0);
        chk("resp_count", resp_cnt, pushes);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
